// File: rtl/switch_debounce_pkg.sv
// Shared definitions for the slide-switch debounce controller: register map
// and the per-bit debounce state encoding.
package switch_debounce_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RAW     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_PERIOD  = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;

  typedef enum logic {STABLE, SETTLING} state_t;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch lane: 2-flop synchroniser, settle FSM and countdown timer.
// o_commit is asserted in the cycle whose edge updates o_debounced.
module switch_debounce_bit #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_raw,
  input  logic [CNT_W-1:0] i_peff,
  output logic             o_sync,
  output logic             o_debounced,
  output logic             o_commit,
  output logic             o_settling
);
  import switch_debounce_pkg::*;

  logic             r_s1;
  logic             r_s2;
  logic             r_deb;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_deb   <= 1'b0;
      r_state <= STABLE;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      case (r_state)
        STABLE: begin
          if (r_s2 != r_deb) begin
            r_state <= SETTLING;
            r_cnt   <= i_peff - 1'b1;
          end
        end
        SETTLING: begin
          // Returning to the committed level before expiry is a rejected bounce
          if (r_s2 == r_deb) begin
            r_state <= STABLE;
          end else if (r_cnt == '0) begin
            r_deb   <= r_s2;
            r_state <= STABLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= STABLE;
      endcase
    end
  end

  assign o_sync      = r_s2;
  assign o_debounced = r_deb;
  assign o_settling  = (r_state == SETTLING);
  assign o_commit    = (r_state == SETTLING) && (r_s2 != r_deb) && (r_cnt == '0);

endmodule

// File: rtl/switch_debounce_ctrl.sv
// Avalon-MM slide-switch controller: per-bit debounce lanes, W1C edge capture,
// maskable level interrupt and a registered read mux.
module switch_debounce_ctrl #(
  parameter int WIDTH          = 4,
  parameter int CNT_W          = 20,
  parameter int DEFAULT_PERIOD = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  import switch_debounce_pkg::*;

  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edgecap;
  logic [CNT_W-1:0] r_period;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_commit;
  logic [WIDTH-1:0] w_settling;
  logic [WIDTH-1:0] w_clr;
  logic [CNT_W-1:0] w_peff;
  logic [31:0]      w_rdmux;
  logic             w_wr;
  logic             w_unused;

  assign w_wr     = chipselect && !write_n;
  assign w_peff   = (r_period == '0) ? CNT_W'(1) : r_period;
  assign w_clr    = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign w_unused = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    switch_debounce_bit #(.CNT_W(CNT_W)) u_bit (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_raw       (in_port[g]),
      .i_peff      (w_peff),
      .o_sync      (w_sync[g]),
      .o_debounced (w_deb[g]),
      .o_commit    (w_commit[g]),
      .o_settling  (w_settling[g])
    );
  end

  always_comb begin
    w_rdmux = '0;
    case (address)
      ADDR_DATA:    w_rdmux[WIDTH-1:0] = w_deb;
      ADDR_RAW:     w_rdmux[WIDTH-1:0] = w_sync;
      ADDR_IRQMASK: w_rdmux[WIDTH-1:0] = r_mask;
      ADDR_EDGECAP: w_rdmux[WIDTH-1:0] = r_edgecap;
      ADDR_PERIOD:  w_rdmux[CNT_W-1:0] = r_period;
      ADDR_STATUS:  w_rdmux[0]         = |w_settling;
      default:      w_rdmux            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask    <= '0;
      r_edgecap <= '0;
      r_period  <= CNT_W'(DEFAULT_PERIOD);
      readdata  <= '0;
    end else begin
      readdata <= w_rdmux;
      if (w_wr && address == ADDR_IRQMASK) r_mask   <= writedata[WIDTH-1:0];
      if (w_wr && address == ADDR_PERIOD)  r_period <= writedata[CNT_W-1:0];
      // A commit landing with a W1C on the same bit keeps the flag set
      r_edgecap <= (r_edgecap & ~w_clr) | w_commit;
    end
  end

  // Both operands are flops, so the bus never reaches irq combinationally
  assign irq = |(r_edgecap & r_mask);

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Bench for switch_debounce_ctrl: directed test-plan steps plus random bounce
// traffic, checked every cycle against a run-length reference model.
module tb_switch_debounce_ctrl;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '0;
  logic          irq;

  always #5 clk = ~clk;

  switch_debounce_ctrl #(.WIDTH(W), .CNT_W(20), .DEFAULT_PERIOD(50000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "reset";

  // Reference model: a level must differ from the committed level on
  // Peff+1 consecutive sampled cycles (two cycles after the pin) to commit.
  logic [W-1:0]  m_s1, m_s2, m_deb, m_mask, m_ec;
  logic [19:0]   m_period;
  int            m_run[W];
  int            m_lat[W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0; m_ec = '0;
    m_period = 20'd50000;
    for (int b = 0; b < W; b++) begin m_run[b] = 0; m_lat[b] = 0; end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic busy;
    busy = 1'b0;
    for (int b = 0; b < W; b++) if (m_run[b] > 0) busy = 1'b1;
    case (a)
      3'd0: return 32'(m_deb);
      3'd1: return 32'(m_s2);
      3'd2: return 32'(m_mask);
      3'd3: return 32'(m_ec);
      3'd4: return 32'(m_period);
      3'd5: return 32'(busy);
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock: update the model from the pre-edge inputs, then check.
  task automatic tick();
    logic [31:0]  exp_rd;
    logic [W-1:0] commits;
    int           peff;
    exp_rd  = m_read(address);
    commits = '0;
    peff    = (m_period == 0) ? 1 : int'(m_period);
    for (int b = 0; b < W; b++) begin
      if (m_s2[b] != m_deb[b]) begin
        if (m_run[b] == 0) m_lat[b] = peff;
        m_run[b]++;
        if (m_run[b] == m_lat[b] + 1) begin
          commits[b] = 1'b1;
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_deb = m_deb ^ commits;
    m_s2  = m_s1;
    m_s1  = in_port;
    if (chipselect && !write_n) begin
      case (address)
        3'd2: m_mask   = writedata[W-1:0];
        3'd3: m_ec     = m_ec & ~writedata[W-1:0];
        3'd4: m_period = writedata[19:0];
        default: ;
      endcase
    end
    m_ec = m_ec | commits;
    @(posedge clk);
    #1;
    chk({phase, "/readdata"}, readdata, exp_rd);
    chk({phase, "/irq"}, 32'(irq), 32'(|(m_ec & m_mask)));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    tick();
    v = readdata;
  endtask

  initial begin
    logic [31:0]  v;
    logic [W-1:0] t;
    int           r;

    model_reset();
    #12;
    chk("reset/readdata_held", readdata, 32'd0);
    chk("reset/irq_held", 32'(irq), 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      chk($sformatf("reset/addr%0d", a), v, (a == 4) ? 32'd50000 : 32'd0);
    end

    phase = "clean";
    wr(3'd4, 32'd4);
    wr(3'd2, 32'h1);
    in_port = 4'h1;
    tick(); tick();
    rd(3'd1, v); chk("clean/raw_after_edge2", v, 32'h1);
    rd(3'd5, v); chk("clean/status_settling", v, 32'h1);
    tick(); tick(); tick();
    chk("clean/irq_after_edge7", 32'(irq), 32'd1);
    rd(3'd0, v); chk("clean/data", v, 32'h1);
    rd(3'd3, v); chk("clean/edgecap", v, 32'h1);

    phase = "bounce";
    wr(3'd4, 32'd8);
    in_port = 4'h5;
    repeat (5) tick();
    in_port = 4'h1;
    repeat (15) tick();
    rd(3'd0, v); chk("bounce/data", v, 32'h1);
    rd(3'd3, v); chk("bounce/edgecap", v, 32'h1);
    rd(3'd5, v); chk("bounce/status", v, 32'h0);

    phase = "w1c_race";
    wr(3'd2, 32'h3);
    wr(3'd4, 32'd4);
    in_port = 4'h3;
    repeat (6) tick();
    wr(3'd3, 32'h3);
    rd(3'd3, v); chk("w1c_race/edgecap", v, 32'h2);
    wr(3'd3, 32'h2);
    rd(3'd3, v); chk("w1c_race/cleared", v, 32'h0);
    chk("w1c_race/irq_low", 32'(irq), 32'd0);

    phase = "period0";
    wr(3'd4, 32'd0);
    in_port = 4'hB;
    repeat (3) tick();
    rd(3'd0, v); chk("period0/before_edge4", v, 32'h3);
    rd(3'd0, v); chk("period0/after_edge4", v, 32'hB);
    wr(3'd4, 32'd1);
    in_port = 4'h3;
    repeat (3) tick();
    rd(3'd0, v); chk("period1/before_edge4", v, 32'hB);
    rd(3'd0, v); chk("period1/after_edge4", v, 32'h3);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12) begin
        t = '0;
        t[$urandom_range(0, W-1)] = 1'b1;
        in_port = in_port ^ t;
      end
      address = 3'($urandom_range(0, 7));
      if (r >= 90) begin
        writedata  = (address == 3'd4) ? 32'($urandom_range(0, 5)) : $urandom;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end else if (r >= 85) begin
        writedata  = 32'hFFFF_FFFF;
        chipselect = 1'b0;
        write_n    = 1'b0;
      end
      tick();
      chipselect = 1'b0; write_n = 1'b1;
    end

    phase = "reset_mid";
    in_port = '0;
    wr(3'd4, 32'd100);
    repeat (110) tick();
    in_port = 4'h1;
    repeat (50) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("reset_mid/readdata_async", readdata, 32'd0);
    chk("reset_mid/irq_async", 32'(irq), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    address = 3'd0;
    repeat (50002) tick();
    rd(3'd0, v); chk("reset_mid/before_commit", v, 32'h0);
    rd(3'd0, v); chk("reset_mid/commit_50003", v, 32'h1);
    rd(3'd3, v); chk("reset_mid/edgecap", v, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
